// File: rtl/qoi_decoder_if.sv
// Host bus for the QOI decoder: chip select, direction, address and data.
interface qoi_decoder_if;
  logic       cs;
  logic       we;
  logic [2:0] addr;
  logic [7:0] data_i;
  logic [7:0] data_o;

  // Host side drives the access and samples read data.
  modport master (output cs, we, addr, data_i, input data_o);

  // Decoder side accepts the access and returns read data.
  modport slave (input cs, we, addr, data_i, output data_o);
endinterface

// File: rtl/qoi_decoder.sv
// Memory-mapped QOI chunk decoder. The host pushes encoded chunk bytes into
// reg0 and pulls decoded RGBA pixels back out of reg0, one byte per access.
// The block keeps the previous pixel, the 64-entry color index and the
// run counter.
module qoi_decoder (
  input logic          clk,
  input logic          rst,
  qoi_decoder_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_OP, S_ARG, S_EMIT, S_DONE} state_t;
  typedef enum logic [1:0] {K_RGB, K_RGBA, K_LUMA} kind_t;

  state_t           state_q, state_d;
  kind_t            kind_q;
  logic [1:0]       arg_cnt;
  logic [5:0]       dg_tag;
  logic [29:0]      count;
  logic [29:0]      size;
  logic [5:0]       run;
  logic [1:0]       out_byte;
  // Pixels are packed with r in byte 0 and alpha in byte 3.
  logic [3:0][7:0]  px;
  logic [3:0][7:0]  prev_px;
  logic [3:0][7:0]  color_index [64];

  logic in_ready, out_valid, working;
  logic wr0, rd0, wr3, wr_size, start;
  logic accept, last_read, arg_last, hit_size;
  logic is_rgb, is_rgba, is_luma, is_index, is_diff, is_run;
  logic [7:0] luma_dg;
  logic [7:0] diff_r, diff_g, diff_b;
  logic [7:0] luma_r, luma_g, luma_b;

  // Sum is kept at full width before truncation so the mod-64 is exact.
  function automatic logic [5:0] qoi_hash(input logic [3:0][7:0] p);
    logic [12:0] sum;
    sum = {5'd0, p[0]} * 13'd3 + {5'd0, p[1]} * 13'd5 +
          {5'd0, p[2]} * 13'd7 + {5'd0, p[3]} * 13'd11;
    return sum[5:0];
  endfunction

  // Bus strobes, status flags and tag classification.
  always_comb begin
    in_ready  = (state_q == S_OP) || (state_q == S_ARG);
    out_valid = (state_q == S_EMIT);
    working   = in_ready || out_valid;

    wr0     = bus.cs && bus.we && (bus.addr == 3'd0);
    rd0     = bus.cs && !bus.we && (bus.addr == 3'd0);
    wr3     = bus.cs && bus.we && (bus.addr == 3'd3);
    wr_size = bus.cs && bus.we && bus.addr[2];
    start   = wr3 && bus.data_i[7] && !working;

    accept    = wr0 && in_ready;
    last_read = rd0 && out_valid && (out_byte == 2'd3);
    hit_size  = ((count + 30'd1) == size);

    is_rgb   = (bus.data_i == 8'hFE);
    is_rgba  = (bus.data_i == 8'hFF);
    is_luma  = (bus.data_i[7:6] == 2'b10);
    is_index = (bus.data_i[7:6] == 2'b00);
    is_diff  = (bus.data_i[7:6] == 2'b01);
    is_run   = (bus.data_i[7:6] == 2'b11) && !is_rgb && !is_rgba;

    arg_last = ((kind_q == K_RGB)  && (arg_cnt == 2'd2)) ||
               ((kind_q == K_RGBA) && (arg_cnt == 2'd3)) ||
               (kind_q == K_LUMA);
  end

  // Channel arithmetic for the single-byte DIFF and the two-byte LUMA chunks.
  always_comb begin
    diff_r  = prev_px[0] + {6'd0, bus.data_i[5:4]} - 8'd2;
    diff_g  = prev_px[1] + {6'd0, bus.data_i[3:2]} - 8'd2;
    diff_b  = prev_px[2] + {6'd0, bus.data_i[1:0]} - 8'd2;
    luma_dg = {2'd0, dg_tag} - 8'd32;
    luma_r  = prev_px[0] + luma_dg + {4'd0, bus.data_i[7:4]} - 8'd8;
    luma_g  = prev_px[1] + luma_dg;
    luma_b  = prev_px[2] + luma_dg + {4'd0, bus.data_i[3:0]} - 8'd8;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decision: tag dispatch, argument collection, pixel drain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = (size == 30'd0) ? S_DONE : S_OP;
      end
      S_OP: begin
        if (accept) begin
          if (is_index || is_diff || is_run) state_d = S_EMIT;
          else                               state_d = S_ARG;
        end
      end
      S_ARG: begin
        if (accept && arg_last) state_d = S_EMIT;
      end
      S_EMIT: begin
        if (last_read) begin
          if (hit_size)         state_d = S_DONE;
          else if (run != 6'd0) state_d = S_EMIT;
          else                  state_d = S_OP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: size register, decode state, pixel assembly and commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      kind_q   <= K_RGB;
      arg_cnt  <= 2'd0;
      dg_tag   <= 6'd0;
      count    <= 30'd0;
      size     <= 30'd0;
      run      <= 6'd0;
      out_byte <= 2'd0;
      px       <= 32'hFF00_0000;
      prev_px  <= 32'hFF00_0000;
      for (int i = 0; i < 64; i++) color_index[i] <= 32'd0;
    end else begin
      if (wr_size) begin
        case (bus.addr[1:0])
          2'd0: size[7:0]   <= bus.data_i;
          2'd1: size[15:8]  <= bus.data_i;
          2'd2: size[23:16] <= bus.data_i;
          default: size[29:24] <= bus.data_i[5:0];
        endcase
      end

      if (start) begin
        count    <= 30'd0;
        run      <= 6'd0;
        out_byte <= 2'd0;
        prev_px  <= 32'hFF00_0000;
        for (int i = 0; i < 64; i++) color_index[i] <= 32'd0;
      end

      if (accept && (state_q == S_OP)) begin
        arg_cnt  <= 2'd0;
        dg_tag   <= bus.data_i[5:0];
        out_byte <= 2'd0;
        if (is_rgb) begin
          kind_q <= K_RGB;
          px     <= prev_px;
        end else if (is_rgba) begin
          kind_q <= K_RGBA;
          px     <= prev_px;
        end else if (is_luma) begin
          kind_q <= K_LUMA;
          px     <= prev_px;
        end else if (is_index) begin
          px <= color_index[bus.data_i[5:0]];
        end else if (is_diff) begin
          px <= {prev_px[3], diff_b, diff_g, diff_r};
        end else begin
          px  <= prev_px;
          run <= bus.data_i[5:0];
        end
      end

      if (accept && (state_q == S_ARG)) begin
        arg_cnt <= arg_cnt + 2'd1;
        if (kind_q == K_LUMA) begin
          px[0] <= luma_r;
          px[1] <= luma_g;
          px[2] <= luma_b;
        end else begin
          px[arg_cnt] <= bus.data_i;
        end
      end

      if (rd0 && out_valid) begin
        out_byte <= out_byte + 2'd1;
        if (out_byte == 2'd3) begin
          prev_px              <= px;
          color_index[qoi_hash(px)] <= px;
          count                <= count + 30'd1;
          if (hit_size)         run <= 6'd0;
          else if (run != 6'd0) run <= run - 6'd1;
        end
      end
    end
  end

  // Read mux: pixel bytes, status and the emitted-pixel counter.
  always_comb begin
    bus.data_o = 8'h00;
    case (bus.addr)
      3'd0: bus.data_o = out_valid ? px[out_byte] : 8'h00;
      3'd3: bus.data_o = {working, 3'b000, out_byte, out_valid, in_ready};
      3'd4: bus.data_o = count[7:0];
      3'd5: bus.data_o = count[15:8];
      3'd6: bus.data_o = count[23:16];
      3'd7: bus.data_o = {2'b00, count[29:24]};
      default: bus.data_o = 8'h00;
    endcase
  end

  logic unused_last_read;
  assign unused_last_read = last_read;

endmodule

// File: tb/tb_qoi_decoder.sv
// Directed bench for qoi_decoder: each task drives one scenario over the
// host bus and compares register reads against hand-computed values.
module tb_qoi_decoder;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  qoi_decoder_if bus_if ();

  qoi_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    bus_if.cs     = 1'b1;
    bus_if.we     = 1'b1;
    bus_if.addr   = a;
    bus_if.data_i = d;
    @(posedge clk);
    #1;
    bus_if.cs = 1'b0;
    bus_if.we = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    bus_if.cs   = 1'b1;
    bus_if.we   = 1'b0;
    bus_if.addr = a;
    #1;
    d = bus_if.data_o;
    @(posedge clk);
    #1;
    bus_if.cs = 1'b0;
  endtask

  task automatic read_pixel(output logic [31:0] p);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      bus_read(3'd0, b);
      p = {p[23:0], b};
    end
  endtask

  task automatic set_size(input logic [29:0] n);
    bus_write(3'd4, n[7:0]);
    bus_write(3'd5, n[15:8]);
    bus_write(3'd6, n[23:16]);
    bus_write(3'd7, {2'b00, n[29:24]});
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    bus_read(3'd3, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("[TB] FAIL reset_reg3 got=%h want=00", v); end
    bus_read(3'd0, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("[TB] FAIL reset_reg0 got=%h want=00", v); end
    for (int a = 4; a < 8; a++) begin
      bus_read(3'(a), v);
      total++;
      if (v !== 8'h00) begin bad++; $display("[TB] FAIL reset_count%0d got=%h want=00", a, v); end
    end
  endtask

  task automatic test_rgb();
    logic [7:0]  v;
    logic [31:0] p;
    set_size(30'd1);
    bus_write(3'd3, 8'h80);
    bus_read(3'd3, v);
    total++;
    if (v !== 8'h81) begin bad++; $display("[TB] FAIL rgb_op_status got=%h want=81", v); end
    bus_write(3'd0, 8'hFE);
    bus_write(3'd0, 8'h10);
    bus_write(3'd0, 8'h20);
    bus_write(3'd0, 8'h30);
    bus_read(3'd3, v);
    total++;
    if (v !== 8'h82) begin bad++; $display("[TB] FAIL rgb_emit_status got=%h want=82", v); end
    read_pixel(p);
    total++;
    if (p !== 32'h102030FF) begin bad++; $display("[TB] FAIL rgb_pixel got=%h want=102030ff", p); end
    bus_read(3'd3, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("[TB] FAIL rgb_done_status got=%h want=00", v); end
    bus_read(3'd4, v);
    total++;
    if (v !== 8'h01) begin bad++; $display("[TB] FAIL rgb_count got=%h want=01", v); end
  endtask

  task automatic test_diff_luma();
    logic [7:0]  v;
    logic [31:0] p;
    set_size(30'd2);
    bus_write(3'd3, 8'h80);
    bus_write(3'd0, 8'h7F);
    read_pixel(p);
    total++;
    if (p !== 32'h010101FF) begin bad++; $display("[TB] FAIL diff_pixel got=%h want=010101ff", p); end
    bus_write(3'd0, 8'hA2);
    bus_write(3'd0, 8'h99);
    read_pixel(p);
    total++;
    if (p !== 32'h040304FF) begin bad++; $display("[TB] FAIL luma_pixel got=%h want=040304ff", p); end
    bus_read(3'd3, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("[TB] FAIL diff_luma_done got=%h want=00", v); end
  endtask

  task automatic test_run_truncate();
    logic [7:0]  v;
    logic [31:0] p;
    set_size(30'd3);
    bus_write(3'd3, 8'h80);
    bus_write(3'd0, 8'hC4);
    for (int i = 0; i < 3; i++) begin
      read_pixel(p);
      total++;
      if (p !== 32'h000000FF) begin bad++; $display("[TB] FAIL run_pixel%0d got=%h want=000000ff", i, p); end
    end
    bus_read(3'd3, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("[TB] FAIL run_done got=%h want=00", v); end
    bus_write(3'd0, 8'h55);
    bus_read(3'd3, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("[TB] FAIL run_dropped_status got=%h want=00", v); end
    bus_read(3'd0, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("[TB] FAIL run_dropped_data got=%h want=00", v); end
    bus_read(3'd4, v);
    total++;
    if (v !== 8'h03) begin bad++; $display("[TB] FAIL run_count got=%h want=03", v); end
  endtask

  task automatic test_index();
    logic [31:0] p;
    set_size(30'd2);
    bus_write(3'd3, 8'h80);
    bus_write(3'd0, 8'hFE);
    bus_write(3'd0, 8'h10);
    bus_write(3'd0, 8'h20);
    bus_write(3'd0, 8'h30);
    read_pixel(p);
    total++;
    if (p !== 32'h102030FF) begin bad++; $display("[TB] FAIL index_first got=%h want=102030ff", p); end
    bus_write(3'd0, 8'h15);
    read_pixel(p);
    total++;
    if (p !== 32'h102030FF) begin bad++; $display("[TB] FAIL index_lookup got=%h want=102030ff", p); end
  endtask

  task automatic test_robust();
    logic [7:0]  v;
    logic [31:0] p;
    set_size(30'd3);
    bus_write(3'd3, 8'h80);
    bus_read(3'd0, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("[TB] FAIL op_read_data got=%h want=00", v); end
    bus_read(3'd3, v);
    total++;
    if (v !== 8'h81) begin bad++; $display("[TB] FAIL op_read_status got=%h want=81", v); end
    bus_write(3'd0, 8'hFE);
    bus_write(3'd3, 8'h80);
    bus_write(3'd0, 8'h01);
    bus_write(3'd0, 8'h02);
    bus_write(3'd0, 8'h03);
    read_pixel(p);
    total++;
    if (p !== 32'h010203FF) begin bad++; $display("[TB] FAIL mid_start_pixel got=%h want=010203ff", p); end
    bus_read(3'd4, v);
    total++;
    if (v !== 8'h01) begin bad++; $display("[TB] FAIL mid_start_count got=%h want=01", v); end
    bus_write(3'd0, 8'h40);
    bus_read(3'd0, v);
    total++;
    if (v !== 8'hFF) begin bad++; $display("[TB] FAIL diff_neg_r got=%h want=ff", v); end
    bus_read(3'd0, v);
    bus_read(3'd3, v);
    total++;
    if (v !== 8'h8A) begin bad++; $display("[TB] FAIL emit_partial_status got=%h want=8a", v); end
    pulse_reset();
    bus_read(3'd3, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("[TB] FAIL rst_emit_status got=%h want=00", v); end
    bus_read(3'd0, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("[TB] FAIL rst_emit_data got=%h want=00", v); end
    bus_read(3'd4, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("[TB] FAIL rst_emit_count got=%h want=00", v); end
    bus_write(3'd3, 8'h80);
    bus_read(3'd3, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("[TB] FAIL size0_start got=%h want=00", v); end
  endtask

  // Scenario sequence and summary.
  initial begin
    total         = 0;
    bad           = 0;
    rst           = 1'b1;
    bus_if.cs     = 1'b0;
    bus_if.we     = 1'b0;
    bus_if.addr   = 3'd0;
    bus_if.data_i = 8'h00;
    test_reset();
    test_rgb();
    test_diff_luma();
    test_run_truncate();
    test_index();
    test_robust();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
